// File: rtl/rv_scoreboard_pkg.sv
// Shared definitions for the rv_scoreboard hazard controller: default sizes,
// register-index width, flush-state encoding and a status bundle for logging.
package rv_scoreboard_pkg;

    localparam int unsigned NREG_DEF         = 32;
    localparam int unsigned MAX_PEND_DEF     = 3;
    localparam int unsigned MAX_INFLIGHT_DEF = 8;
    localparam int unsigned FLUSH_DEPTH_DEF  = 2;

    localparam int unsigned RIDX_W = $clog2(NREG_DEF);
    localparam int unsigned INF_W  = $clog2(MAX_INFLIGHT_DEF + 1);

    typedef enum logic {
        FS_IDLE  = 1'b0,
        FS_FLUSH = 1'b1
    } flush_state_e;

    typedef struct packed {
        logic [NREG_DEF-1:0] pend_vec;
        logic [INF_W-1:0]    inflight;
        logic                err_underflow;
    } sb_status_t;

endpackage

// File: rtl/rv_scoreboard_if.sv
// Issue / write-back / branch signal bundle between decode, exec and the
// scoreboard. master drives requests, slave is the scoreboard.
interface rv_scoreboard_if #(
    parameter int unsigned NREG         = 32,
    parameter int unsigned MAX_INFLIGHT = 8
);
    localparam int unsigned RIDX_W = $clog2(NREG);
    localparam int unsigned INF_W  = $clog2(MAX_INFLIGHT + 1);

    logic              iss_valid;
    logic [RIDX_W-1:0] iss_rd;
    logic              iss_rd_we;
    logic [RIDX_W-1:0] iss_rs1;
    logic              iss_rs1_use;
    logic [RIDX_W-1:0] iss_rs2;
    logic              iss_rs2_use;
    logic              iss_ready;
    logic              stall;
    logic              wb_valid;
    logic [RIDX_W-1:0] wb_rd;
    logic              br_taken;
    logic              flush;
    logic [NREG-1:0]   pend_vec;
    logic [INF_W-1:0]  inflight;
    logic              err_underflow;

    modport master (
        output iss_valid, iss_rd, iss_rd_we, iss_rs1, iss_rs1_use,
               iss_rs2, iss_rs2_use, wb_valid, wb_rd, br_taken,
        input  iss_ready, stall, flush, pend_vec, inflight, err_underflow
    );

    modport slave (
        input  iss_valid, iss_rd, iss_rd_we, iss_rs1, iss_rs1_use,
               iss_rs2, iss_rs2_use, wb_valid, wb_rd, br_taken,
        output iss_ready, stall, flush, pend_vec, inflight, err_underflow
    );

endinterface

// File: rtl/rv_scoreboard_flush_seq.sv
// Control-hazard flush sequencer: holds flush high for FLUSH_DEPTH cycles after
// the latest taken branch/jump; a new branch reloads the window.
module rv_flush_seq
    import rv_scoreboard_pkg::*;
#(
    parameter int unsigned FLUSH_DEPTH = FLUSH_DEPTH_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_br_taken,
    output logic o_flush
);
    localparam int unsigned CNT_W = (FLUSH_DEPTH < 2) ? 1 : $clog2(FLUSH_DEPTH + 1);

    flush_state_e     r_state;
    flush_state_e     w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FS_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // r_cnt counts the flush cycles still to be shown, including the current one
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (i_br_taken) begin
            w_state_nxt = FS_FLUSH;
            w_cnt_nxt   = CNT_W'(FLUSH_DEPTH);
        end else if (r_state == FS_FLUSH) begin
            if (r_cnt <= CNT_W'(1)) begin
                w_state_nxt = FS_IDLE;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt   = r_cnt - CNT_W'(1);
            end
        end
    end

    assign o_flush = (r_state == FS_FLUSH);

endmodule

// File: rtl/rv_scoreboard.sv
// Per-register outstanding-write scoreboard with RAW/WAW/in-flight stalls and
// branch flush. Optional RV_SCOREBOARD_BYPASS_EN lets a source whose last
// pending write completes this cycle issue without stalling.
module rv_scoreboard
    import rv_scoreboard_pkg::*;
#(
    parameter int unsigned NREG         = NREG_DEF,
    parameter int unsigned MAX_PEND     = MAX_PEND_DEF,
    parameter int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEF,
    parameter int unsigned FLUSH_DEPTH  = FLUSH_DEPTH_DEF
) (
    input  logic           CLK,
    input  logic           RST,
    rv_scoreboard_if.slave sb
);
    localparam int unsigned IDX_W = $clog2(NREG);
    localparam int unsigned CNT_W = $clog2(MAX_PEND + 1);
    localparam int unsigned IF_W  = $clog2(MAX_INFLIGHT + 1);

    logic [CNT_W-1:0] r_count     [NREG];
    logic [CNT_W-1:0] w_count_nxt [NREG];
    logic [IF_W-1:0]  r_inflight;
    logic             r_err;
    logic [NREG-1:0]  w_pend;

    logic w_rd_wr, w_wb_hit, w_wb_dec, w_wb_under;
    logic w_raw1, w_raw2, w_pend_full, w_inf_full;
    logic w_ready, w_inc, w_flush;

    assign w_rd_wr    = sb.iss_rd_we & (sb.iss_rd != '0);
    assign w_wb_hit   = sb.wb_valid & (sb.wb_rd != '0);
    assign w_wb_dec   = w_wb_hit & (r_count[sb.wb_rd] != '0);
    assign w_wb_under = w_wb_hit & (r_count[sb.wb_rd] == '0);

    // RAW detection; bypass forgives a source whose single pending write retires now
    always_comb begin
        w_raw1 = sb.iss_rs1_use & (sb.iss_rs1 != '0) & (r_count[sb.iss_rs1] != '0);
        w_raw2 = sb.iss_rs2_use & (sb.iss_rs2 != '0) & (r_count[sb.iss_rs2] != '0);
`ifdef RV_SCOREBOARD_BYPASS_EN
        if ((r_count[sb.iss_rs1] == CNT_W'(1)) && sb.wb_valid && (sb.wb_rd == sb.iss_rs1)) begin
            w_raw1 = 1'b0;
        end
        if ((r_count[sb.iss_rs2] == CNT_W'(1)) && sb.wb_valid && (sb.wb_rd == sb.iss_rs2)) begin
            w_raw2 = 1'b0;
        end
`endif
    end

    assign w_pend_full = w_rd_wr & (r_count[sb.iss_rd] == CNT_W'(MAX_PEND));
    assign w_inf_full  = w_rd_wr & (r_inflight == IF_W'(MAX_INFLIGHT)) & ~w_wb_dec;
    assign w_ready     = sb.iss_valid & ~w_flush & ~w_raw1 & ~w_raw2 & ~w_pend_full & ~w_inf_full;
    assign w_inc       = w_ready & w_rd_wr;

    for (genvar r = 0; r < NREG; r++) begin : g_cnt
        if (r == 0) begin : g_zero
            assign w_count_nxt[r] = '0;
        end else begin : g_reg
            logic w_up, w_dn;
            assign w_up = w_inc & (sb.iss_rd == IDX_W'(r));
            assign w_dn = w_wb_dec & (sb.wb_rd == IDX_W'(r));
            assign w_count_nxt[r] = (w_up & ~w_dn) ? r_count[r] + CNT_W'(1) :
                                    (w_dn & ~w_up) ? r_count[r] - CNT_W'(1) :
                                                     r_count[r];
        end
        assign w_pend[r] = (r_count[r] != '0);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_count    <= '{default: '0};
            r_inflight <= '0;
            r_err      <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_inflight <= r_inflight + IF_W'(w_inc) - IF_W'(w_wb_dec);
            if (w_wb_under) begin
                r_err <= 1'b1;
            end
        end
    end

    rv_flush_seq #(
        .FLUSH_DEPTH (FLUSH_DEPTH)
    ) u_flush_seq (
        .clk        (CLK),
        .rst_n      (RST),
        .i_br_taken (sb.br_taken),
        .o_flush    (w_flush)
    );

    assign sb.iss_ready     = w_ready;
    assign sb.stall         = sb.iss_valid & ~w_ready;
    assign sb.flush         = w_flush;
    assign sb.pend_vec      = w_pend;
    assign sb.inflight      = r_inflight;
    assign sb.err_underflow = r_err;

endmodule

// File: tb/tb_rv_scoreboard.sv
// Self-checking bench for rv_scoreboard: directed hazard scenarios followed by
// random issue/write-back/branch traffic against a counting reference model.
module tb_rv_scoreboard;

    localparam int unsigned NREG   = 32;
    localparam int unsigned MAXP   = 3;
    localparam int unsigned MAXINF = 8;
    localparam int unsigned FDEPTH = 2;
    localparam int unsigned IW     = $clog2(NREG);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rv_scoreboard_if #(.NREG(NREG), .MAX_INFLIGHT(MAXINF)) sb_if ();

    rv_scoreboard #(
        .NREG         (NREG),
        .MAX_PEND     (MAXP),
        .MAX_INFLIGHT (MAXINF),
        .FLUSH_DEPTH  (FDEPTH)
    ) dut (
        .CLK (clk),
        .RST (rst_n),
        .sb  (sb_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model: outstanding writes per register, totals, flush window
    int m_cnt [NREG];
    int m_infl;
    bit m_err;
    int m_flush_left;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_raw(input int s, input bit use_s, input bit wv, input int wrd);
        bit haz;
        haz = use_s && (s != 0) && (m_cnt[s] != 0);
`ifdef RV_SCOREBOARD_BYPASS_EN
        if (m_cnt[s] == 1 && wv && wrd == s) haz = 1'b0;
`endif
        return haz;
    endfunction

    function automatic longint m_pend();
        longint v = 0;
        for (int r = 1; r < NREG; r++) if (m_cnt[r] != 0) v |= (longint'(1) << r);
        return v;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
        m_infl       = 0;
        m_err        = 1'b0;
        m_flush_left = 0;
    endtask

    task automatic drive_idle();
        sb_if.iss_valid   = 1'b0;
        sb_if.iss_rd      = '0;
        sb_if.iss_rd_we   = 1'b0;
        sb_if.iss_rs1     = '0;
        sb_if.iss_rs1_use = 1'b0;
        sb_if.iss_rs2     = '0;
        sb_if.iss_rs2_use = 1'b0;
        sb_if.wb_valid    = 1'b0;
        sb_if.wb_rd       = '0;
        sb_if.br_taken    = 1'b0;
    endtask

    task automatic check_regs(input string where);
        check({where, ".pend_vec"}, sb_if.pend_vec, m_pend());
        check({where, ".inflight"}, sb_if.inflight, m_infl);
        check({where, ".flush"}, sb_if.flush, m_flush_left > 0);
        check({where, ".err_underflow"}, sb_if.err_underflow, m_err);
    endtask

    // asynchronous reset: outputs must clear before any clock edge
    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        #2;
        model_clear();
        check_regs("reset");
        check("reset.iss_ready", sb_if.iss_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // one cycle: apply inputs, check combinational handshake, clock, check state
    task automatic cycle(input bit iv, input int rd, input bit we, input int rs1, input bit u1,
                         input int rs2, input bit u2, input bit wv, input int wrd, input bit br);
        bit exp_ready;
        bit dec;
        bit under;
        sb_if.iss_valid   = iv;
        sb_if.iss_rd      = IW'(rd);
        sb_if.iss_rd_we   = we;
        sb_if.iss_rs1     = IW'(rs1);
        sb_if.iss_rs1_use = u1;
        sb_if.iss_rs2     = IW'(rs2);
        sb_if.iss_rs2_use = u2;
        sb_if.wb_valid    = wv;
        sb_if.wb_rd       = IW'(wrd);
        sb_if.br_taken    = br;
        #2;
        dec   = wv && (wrd != 0) && (m_cnt[wrd] > 0);
        under = wv && (wrd != 0) && (m_cnt[wrd] == 0);
        exp_ready = iv && (m_flush_left == 0)
                 && !m_raw(rs1, u1, wv, wrd) && !m_raw(rs2, u2, wv, wrd)
                 && !(we && rd != 0 && m_cnt[rd] == int'(MAXP))
                 && !(we && rd != 0 && m_infl == int'(MAXINF) && !dec);
        check("iss_ready", sb_if.iss_ready, exp_ready);
        check("stall", sb_if.stall, iv && !exp_ready);
        @(posedge clk);
        if (exp_ready && we && rd != 0) begin
            m_cnt[rd]++;
            m_infl++;
        end
        if (dec) begin
            m_cnt[wrd]--;
            m_infl--;
        end
        if (under) m_err = 1'b1;
        if (br) m_flush_left = FDEPTH;
        else if (m_flush_left > 0) m_flush_left--;
        #1;
        check_regs("cycle");
        drive_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive_idle();
        model_clear();
        do_reset();

        // single issue then completion
        cycle(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        check("issue5.pend_bit", sb_if.pend_vec[5], 1);
        check("issue5.inflight", sb_if.inflight, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 5, 0);
        check("wb5.pend_bit", sb_if.pend_vec[5], 0);
        check("wb5.inflight", sb_if.inflight, 0);

        // RAW stall until write-back, with or without forwarding
        cycle(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        cycle(1, 0, 0, 5, 1, 0, 0, 1, 5, 0);
        cycle(1, 0, 0, 5, 1, 0, 0, 0, 0, 0);

        // per-register pending limit
        do_reset();
        repeat (3) cycle(1, 7, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 7, 1, 0, 0, 0, 0, 0, 0, 0);
        check("waw_full.inflight", sb_if.inflight, 3);
        cycle(1, 7, 1, 0, 0, 0, 0, 1, 7, 0);

        // global in-flight limit
        do_reset();
        for (int i = 1; i <= 8; i++) cycle(1, i, 1, 0, 0, 0, 0, 0, 0, 0);
        check("infl_full.inflight", sb_if.inflight, 8);
        cycle(1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 9, 1, 0, 0, 0, 0, 1, 1, 0);
        check("infl_swap.inflight", sb_if.inflight, 8);
        check("infl_swap.pend9", sb_if.pend_vec[9], 1);

        // flush window and reload
        do_reset();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("br.flush", sb_if.flush, 1);
        repeat (3) cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (3) cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // underflow is sticky, register 0 is inert
        do_reset();
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
        check("under.err", sb_if.err_underflow, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cycle(1, 0, 1, 0, 1, 0, 1, 0, 0, 0);
        check("x0.err_hold", sb_if.err_underflow, 1);
        check("x0.inflight", sb_if.inflight, 0);

        // reset while flushing with writes pending
        cycle(1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 6, 1, 0, 0, 0, 0, 0, 0, 1);
        do_reset();

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            int pend_q[$];
            bit iv, we, u1, u2, wv, br;
            int rd, rs1, rs2, wrd;
            iv  = ($urandom_range(0, 9) < 7);
            rd  = $urandom_range(0, 9);
            we  = ($urandom_range(0, 3) != 0);
            rs1 = $urandom_range(0, 9);
            rs2 = $urandom_range(0, 9);
            u1  = $urandom_range(0, 1);
            u2  = $urandom_range(0, 1);
            br  = ($urandom_range(0, 19) == 0);
            wv  = 1'b0;
            wrd = 0;
            for (int r = 1; r < NREG; r++) if (m_cnt[r] > 0) pend_q.push_back(r);
            if (pend_q.size() > 0 && $urandom_range(0, 9) < 4) begin
                wv  = 1'b1;
                wrd = pend_q[$urandom_range(0, pend_q.size() - 1)];
            end else if ($urandom_range(0, 19) == 0) begin
                wv  = 1'b1;
                wrd = 0;
            end
            cycle(iv, rd, we, rs1, u1, rs2, u2, wv, wrd, br);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
